// File: rtl/sd_spi_responder.sv
// SD card SPI-mode responder: frames host commands, models card init,
// and streams CMD17 single-block reads from a byte-wide memory port.
module sd_spi_responder #(
    parameter int INIT_POLLS = 2,
    parameter int NCR_BYTES  = 1,
    parameter int NAC_BYTES  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        mem_rd,
    output logic [31:0] mem_blk,
    output logic [8:0]  mem_idx,
    input  logic [7:0]  mem_data,
    output logic        card_ready,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index
);

    typedef enum logic [1:0] {
        HUNT, RX_CMD, TX, DISCARD
    } state_t;

    localparam logic [15:0] NCR   = 16'(NCR_BYTES);
    localparam logic [15:0] NAC   = 16'(NAC_BYTES);
    localparam logic [15:0] DLEN  = NAC + 16'd516;
    localparam logic [7:0]  POLLS = 8'(INIT_POLLS);

    state_t state, state_d;

    logic [2:0]  sclk_s;
    logic [1:0]  cs_s, mosi_s;
    logic        rise, fall, cs_hi, mosi_b;

    logic [39:0] rx_sh;
    logic [5:0]  rx_cnt;
    logic        frame_ok, accept;
    logic [5:0]  cmd;
    logic [31:0] arg;

    logic        idle, app, data_mode;
    logic [7:0]  poll;
    logic [39:0] resp_q;
    logic [15:0] tx_len;

    logic        idle_d, app_d, data_d, ready_d;
    logic [7:0]  poll_d, poll_inc, r1;
    logic [39:0] resp_d;
    logic [15:0] len_d;

    logic [15:0] k, r, nr;
    logic [2:0]  bit_cnt;
    logic        need_load, last, fetch;
    logic [7:0]  tx_sh, nb, mem_q;
    logic        mem_rd_q;

    assign rise   = sclk_s[1] & ~sclk_s[2];
    assign fall   = ~sclk_s[1] & sclk_s[2];
    assign cs_hi  = cs_s[1];
    assign mosi_b = mosi_s[1];

    // bits 47..8 of the frame sit in rx_sh; the CRC only gets counted
    assign cmd      = rx_sh[37:32];
    assign arg      = rx_sh[31:0];
    assign frame_ok = ~rx_sh[39] & rx_sh[38] & mosi_b;
    assign accept   = (state == RX_CMD) & rise & ~cs_hi
                    & (rx_cnt == 6'd47) & frame_ok;

    assign r1    = {7'b0, idle};
    assign r     = k - NCR;
    assign nr    = k + 16'd1 - NCR;
    assign last  = (k == tx_len - 16'd1);
    assign fetch = data_mode
                 && nr >= NAC + 16'd2
                 && nr <= NAC + 16'd513;

    // bring the async SPI pins into the clk domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_s <= 3'b000;
            cs_s   <= 2'b11;
            mosi_s <= 2'b11;
        end else begin
            sclk_s <= {sclk_s[1:0], sclk};
            cs_s   <= {cs_s[0], cs_n};
            mosi_s <= {mosi_s[0], mosi};
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= HUNT;
        else      state <= state_d;
    end

    // next state; a deselect overrides any simultaneous sclk edge
    always_comb begin
        state_d = state;
        if (cs_hi) begin
            state_d = DISCARD;
        end else begin
            case (state)
                HUNT:
                    if (rise && !mosi_b) state_d = RX_CMD;
                RX_CMD:
                    if (rise && rx_cnt == 6'd47)
                        state_d = frame_ok ? TX : HUNT;
                TX:
                    if (rise && bit_cnt == 3'd7 && last)
                        state_d = HUNT;
                default:
                    state_d = HUNT;
            endcase
        end
    end

    // command shifter: start bit seeds, then 39 more header bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_cnt <= '0;
            rx_sh  <= '0;
        end else if (!cs_hi && rise) begin
            if (state == HUNT && !mosi_b) begin
                rx_cnt <= 6'd1;
                rx_sh  <= '0;
            end else if (state == RX_CMD) begin
                rx_cnt <= rx_cnt + 6'd1;
                if (rx_cnt < 6'd40)
                    rx_sh <= {rx_sh[38:0], mosi_b};
            end
        end
    end

    // card model: response bytes and init-state updates
    always_comb begin
        idle_d   = idle;
        app_d    = 1'b0;
        poll_d   = poll;
        ready_d  = card_ready;
        data_d   = 1'b0;
        poll_inc = poll;
        len_d    = 16'd1;
        resp_d   = {r1 | 8'h04, 32'hFFFF_FFFF};
        case (cmd)
            6'd0: begin
                idle_d  = 1'b1;
                poll_d  = '0;
                ready_d = 1'b0;
                resp_d  = {8'h01, 32'hFFFF_FFFF};
            end
            6'd8: begin
                resp_d = {r1, 16'h0000,
                          4'h0, arg[11:8], arg[7:0]};
                len_d  = 16'd5;
            end
            6'd16: resp_d = {r1, 32'hFFFF_FFFF};
            6'd17: begin
                if (!idle) begin
                    resp_d = {8'h00, 32'hFFFF_FFFF};
                    data_d = 1'b1;
                    len_d  = DLEN;
                end
            end
            6'd41: begin
                if (app) begin
                    if (poll < POLLS) poll_inc = poll + 8'd1;
                    poll_d = poll_inc;
                    if (poll_inc >= POLLS) begin
                        idle_d  = 1'b0;
                        ready_d = 1'b1;
                    end
                    resp_d = {7'b0, idle_d, 32'hFFFF_FFFF};
                end
            end
            6'd55: begin
                resp_d = {r1, 32'hFFFF_FFFF};
                app_d  = 1'b1;
            end
            6'd58: begin
                resp_d = {r1, 32'hC0FF_8000};
                len_d  = 16'd5;
            end
            default: ;
        endcase
    end

    // card registers, committed once per accepted frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle       <= 1'b1;
            app        <= 1'b0;
            poll       <= '0;
            card_ready <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_index  <= '0;
            resp_q     <= '1;
            tx_len     <= '0;
            data_mode  <= 1'b0;
            mem_blk    <= '0;
        end else begin
            cmd_valid <= accept;
            if (accept) begin
                idle       <= idle_d;
                app        <= app_d;
                poll       <= poll_d;
                card_ready <= ready_d;
                cmd_index  <= cmd;
                resp_q     <= resp_d;
                tx_len     <= NCR + len_d;
                data_mode  <= data_d;
                if (data_d) mem_blk <= arg;
            end
        end
    end

    // byte k of the outgoing stream
    always_comb begin
        nb = 8'hFF;
        if (k >= NCR) begin
            if (!data_mode) begin
                case (r)
                    16'd0: nb = resp_q[39:32];
                    16'd1: nb = resp_q[31:24];
                    16'd2: nb = resp_q[23:16];
                    16'd3: nb = resp_q[15:8];
                    16'd4: nb = resp_q[7:0];
                    default: nb = 8'hFF;
                endcase
            end else if (r == 16'd0) begin
                nb = resp_q[39:32];
            end else if (r <= NAC) begin
                nb = 8'hFF;
            end else if (r == NAC + 16'd1) begin
                nb = 8'hFE;
            end else if (r <= NAC + 16'd513) begin
                nb = mem_q;
            end
        end
    end

    // miso shifter and memory prefetch one byte ahead
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miso      <= 1'b1;
            k         <= '0;
            bit_cnt   <= '0;
            need_load <= 1'b0;
            tx_sh     <= '1;
            mem_rd    <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_idx   <= '0;
            mem_q     <= '0;
        end else begin
            mem_rd   <= 1'b0;
            mem_rd_q <= mem_rd;
            if (mem_rd_q) mem_q <= mem_data;
            if (accept) begin
                miso      <= 1'b1;
                k         <= '0;
                bit_cnt   <= '0;
                need_load <= 1'b1;
            end else if (cs_hi || state != TX) begin
                miso      <= 1'b1;
                need_load <= 1'b0;
            end else begin
                if (fall) begin
                    if (need_load) begin
                        miso      <= nb[7];
                        tx_sh     <= {nb[6:0], 1'b1};
                        need_load <= 1'b0;
                    end else begin
                        miso  <= tx_sh[7];
                        tx_sh <= {tx_sh[6:0], 1'b1};
                    end
                end
                if (rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd0 && fetch) begin
                        mem_rd  <= 1'b1;
                        mem_idx <= 9'(nr - NAC - 16'd2);
                    end
                    if (bit_cnt == 3'd7) begin
                        k         <= k + 16'd1;
                        need_load <= 1'b1;
                        if (last) miso <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: bit-banged SPI host, byte scoreboard,
// memory model returning idx[7:0].
module tb_sd_spi_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, cs_n, mosi;
    logic        miso, mem_rd;
    logic [31:0] mem_blk;
    logic [8:0]  mem_idx;
    logic [7:0]  mem_data = 8'h00;
    logic        card_ready, cmd_valid;
    logic [5:0]  cmd_index;

    int n_chk  = 0;
    int n_fail = 0;
    int vcnt   = 0;
    int rdcnt  = 0;
    int exp_v  = 0;
    int base;

    logic [7:0] exp_q[$];

    sd_spi_responder #(
        .INIT_POLLS(2),
        .NCR_BYTES (1),
        .NAC_BYTES (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .mem_rd    (mem_rd),
        .mem_blk   (mem_blk),
        .mem_idx   (mem_idx),
        .mem_data  (mem_data),
        .card_ready(card_ready),
        .cmd_valid (cmd_valid),
        .cmd_index (cmd_index)
    );

    always #5 clk = ~clk;

    // memory model: data one cycle after the strobe
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem_idx[7:0];
    end

    // event counters
    always @(posedge clk) begin
        if (cmd_valid) vcnt++;
        if (mem_rd) rdcnt++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h",
                     tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx,
                        output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            repeat (4) @(negedge clk);
            rx[i] = miso;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [5:0] c,
                            input logic [31:0] a,
                            input logic [7:0] crc);
        logic [7:0] rx;
        xfer({2'b01, c}, rx);
        xfer(a[31:24], rx);
        xfer(a[23:16], rx);
        xfer(a[15:8], rx);
        xfer(a[7:0], rx);
        xfer(crc, rx);
    endtask

    task automatic drain(input string tag);
        logic [7:0] rx;
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            xfer(8'hFF, rx);
            e = exp_q.pop_front();
            chk(tag, {24'h0, rx}, {24'h0, e});
        end
    endtask

    task automatic push2(input logic [7:0] a,
                         input logic [7:0] b);
        exp_q.push_back(a);
        exp_q.push_back(b);
    endtask

    task automatic hdr17();
        push2(8'hFF, 8'h00);
        push2(8'hFF, 8'hFE);
    endtask

    initial begin
        rst  = 1'b0;
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_miso", {31'h0, miso}, 1);
        chk("rst_mem_rd", {31'h0, mem_rd}, 0);
        chk("rst_mem_blk", mem_blk, 0);
        chk("rst_mem_idx", {23'h0, mem_idx}, 0);
        chk("rst_ready", {31'h0, card_ready}, 0);
        chk("rst_valid", {31'h0, cmd_valid}, 0);
        chk("rst_index", {26'h0, cmd_index}, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);

        push2(8'hFF, 8'h01);
        send_cmd(6'd0, 32'h0, 8'h95);
        exp_v++;
        drain("cmd0");
        chk("cmd0_valid", vcnt, exp_v);
        chk("cmd0_index", {26'h0, cmd_index}, 0);

        push2(8'hFF, 8'h01);
        push2(8'h00, 8'h00);
        push2(8'h01, 8'hAA);
        send_cmd(6'd8, 32'h0000_01AA, 8'h87);
        exp_v++;
        drain("cmd8");
        chk("cmd8_index", {26'h0, cmd_index}, 8);

        push2(8'hFF, 8'h05);
        exp_q.push_back(8'hFF);
        send_cmd(6'd17, 32'h10, 8'h01);
        exp_v++;
        drain("cmd17_idle");

        push2(8'hFF, 8'h01);
        send_cmd(6'd55, 32'h0, 8'h01);
        drain("cmd55_a");
        push2(8'hFF, 8'h01);
        send_cmd(6'd41, 32'h4000_0000, 8'h01);
        drain("acmd41_a");
        chk("ready_early", {31'h0, card_ready}, 0);
        push2(8'hFF, 8'h01);
        send_cmd(6'd55, 32'h0, 8'h01);
        drain("cmd55_b");
        push2(8'hFF, 8'h00);
        send_cmd(6'd41, 32'h4000_0000, 8'h01);
        drain("acmd41_b");
        exp_v += 4;
        chk("ready_set", {31'h0, card_ready}, 1);

        push2(8'hFF, 8'h04);
        send_cmd(6'd41, 32'h0, 8'h01);
        exp_v++;
        drain("cmd41_noapp");

        push2(8'hFF, 8'h00);
        push2(8'hC0, 8'hFF);
        push2(8'h80, 8'h00);
        send_cmd(6'd58, 32'h0, 8'h01);
        exp_v++;
        drain("cmd58");
        chk("cmd58_index", {26'h0, cmd_index}, 58);
        chk("valid_count", vcnt, exp_v);

        base = rdcnt;
        hdr17();
        for (int i = 0; i < 512; i++)
            exp_q.push_back(8'(i));
        push2(8'hFF, 8'hFF);
        exp_q.push_back(8'hFF);
        send_cmd(6'd17, 32'h10, 8'h01);
        exp_v++;
        chk("cmd17_blk", mem_blk, 32'h10);
        drain("cmd17_data");
        chk("cmd17_reads", rdcnt - base, 512);

        begin
            logic [7:0] rx;
            xfer(8'h00, rx);
            xfer(8'h00, rx);
            xfer(8'h00, rx);
            xfer(8'h00, rx);
            xfer(8'h00, rx);
            xfer(8'h01, rx);
        end
        push2(8'hFF, 8'hFF);
        drain("bad_frame");
        chk("bad_valid", vcnt, exp_v);

        base = rdcnt;
        hdr17();
        for (int i = 0; i < 96; i++)
            exp_q.push_back(8'(i));
        send_cmd(6'd17, 32'h10, 8'h01);
        exp_v++;
        drain("abort_data");
        cs_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_miso", {31'h0, miso}, 1);
        chk("abort_reads", rdcnt - base, 97);
        begin
            logic [7:0] rx;
            xfer(8'hFF, rx);
            chk("desel_byte", {24'h0, rx}, 32'hFF);
        end
        chk("abort_nord", rdcnt - base, 97);
        chk("abort_ready", {31'h0, card_ready}, 1);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        push2(8'hFF, 8'h01);
        send_cmd(6'd0, 32'h0, 8'h95);
        exp_v++;
        drain("cmd0_again");
        chk("cmd0_unready", {31'h0, card_ready}, 0);
        chk("valid_count2", vcnt, exp_v);

        for (int j = 0; j < 2; j++) begin
            push2(8'hFF, 8'h01);
            send_cmd(6'd55, 32'h0, 8'h01);
            drain("reinit55");
            push2(8'hFF, (j == 0) ? 8'h01 : 8'h00);
            send_cmd(6'd41, 32'h4000_0000, 8'h01);
            drain("reinit41");
        end
        hdr17();
        for (int i = 0; i < 16; i++)
            exp_q.push_back(8'(i));
        send_cmd(6'd17, 32'h22, 8'h01);
        drain("pre_reset");
        chk("pre_rst_ready", {31'h0, card_ready}, 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_miso", {31'h0, miso}, 1);
        chk("mid_rst_rd", {31'h0, mem_rd}, 0);
        chk("mid_rst_blk", mem_blk, 0);
        chk("mid_rst_idx", {23'h0, mem_idx}, 0);
        chk("mid_rst_ready", {31'h0, card_ready}, 0);
        chk("mid_rst_index", {26'h0, cmd_index}, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        push2(8'hFF, 8'h01);
        exp_q.push_back(8'hFF);
        send_cmd(6'd0, 32'h0, 8'h95);
        drain("post_rst_cmd0");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
